// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage: issues word requests to instruction memory, buffers
// in-order responses in a prefetch FIFO and presents them to ID with valid/ready.
module if_prefetch_stage #(
    parameter int unsigned WORD_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    input  logic                  fetch_en_i,
    input  logic [WORD_WIDTH-1:0] pc_start_address_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [WORD_WIDTH-1:0] instruction_o,
    output logic [WORD_WIDTH-1:0] program_count_o,
    output logic                  empty_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] instr;
    } fifo_entry_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WORD_WIDTH-1:0] r_fetch_addr;
    logic [WORD_WIDTH-1:0] r_aq [MAX_OUTSTANDING];
    logic [QW-1:0]         r_aq_wr;
    logic [QW-1:0]         r_aq_rd;
    fifo_entry_t           r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [OW-1:0]         r_outstanding;
    logic [OW-1:0]         r_discard;

    logic                  w_credit;
    logic                  w_req_raw;
    logic                  w_gnt;
    logic                  w_rvalid;
    logic                  w_push;
    logic                  w_pop;
    logic [OW-1:0]         w_out_next;
    logic [CW-1:0]         w_count_next;
    fifo_entry_t           w_head;

    function automatic logic [QW-1:0] aq_inc(input logic [QW-1:0] p);
        if (32'(p) == 32'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + QW'(1);
    endfunction

    // Outstanding requests include those whose responses will be discarded.
    assign w_credit = ((32'(r_count) + 32'(r_outstanding)) < 32'(FIFO_DEPTH)) &&
                      (32'(r_outstanding) < 32'(MAX_OUTSTANDING));

    // A grant coinciding with a branch is still tracked so its response is dropped.
    assign w_gnt    = instr_gnt_i && w_req_raw;
    assign w_rvalid = instr_rvalid_i && (r_outstanding != '0);
    assign w_push   = w_rvalid && !branch_i && (r_discard == '0);
    assign w_pop    = valid_o && ready_i && !branch_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_raw    = 1'b0;
        instr_req_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_en_i) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_req_raw   = w_credit;
                instr_req_o = w_credit && !branch_i;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (!fetch_en_i) begin
            w_state_next = S_IDLE;
        end
    end

    always_comb begin
        w_out_next = r_outstanding;
        if (w_gnt && !w_rvalid) begin
            w_out_next = r_outstanding + OW'(1);
        end else if (!w_gnt && w_rvalid) begin
            w_out_next = r_outstanding - OW'(1);
        end
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Request-side bookkeeping: fetch address, in-flight counters, address queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_addr  <= pc_start_address_i;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_gnt) begin
                r_aq_wr <= aq_inc(r_aq_wr);
            end
            if (w_rvalid) begin
                r_aq_rd <= aq_inc(r_aq_rd);
            end
            if (branch_i) begin
                r_fetch_addr <= branch_addr_i;
                r_discard    <= w_out_next;
            end else begin
                if (w_gnt) begin
                    r_fetch_addr <= r_fetch_addr + WORD_WIDTH'(4);
                end
                if (w_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - OW'(1);
                end
            end
        end
    end

    // Prefetch FIFO control; a branch empties it in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (branch_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt) begin
            r_aq[r_aq_wr] <= r_fetch_addr;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{addr: r_aq[r_aq_rd], instr: instr_rdata_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_no_push_full: assert (!(w_push && (r_count == CW'(FIFO_DEPTH))));
        end
    end

    assign w_head          = r_fifo[r_rd_ptr];
    assign valid_o         = (r_count != '0);
    assign instruction_o   = valid_o ? w_head.instr : '0;
    assign program_count_o = valid_o ? w_head.addr  : '0;
    assign instr_addr_o    = r_fetch_addr;
    assign empty_o         = (r_count == '0) && (r_outstanding == '0);

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with an in-order memory model whose
// response data is addr + 0xA000; popped instructions are checked in sequence.
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        fetch_en_i;
    logic [31:0] pc_start_address_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] instruction_o;
    logic [31:0] program_count_o;
    logic        empty_o;

    logic        force_gnt;
    logic        gnt_stall;
    logic [31:0] mq_addr [$];
    int          mq_due [$];
    int          lat;
    int          cyc_n;
    int          n_checks;
    int          n_pass;
    int          n_pops;
    logic [31:0] exp_pc;
    logic [31:0] last_gnt;

    always #5 clk = ~clk;

    assign instr_gnt_i = (instr_req_o || force_gnt) && !gnt_stall;

    if_prefetch_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instr_req_o        (instr_req_o),
        .instr_addr_o       (instr_addr_o),
        .instr_gnt_i        (instr_gnt_i),
        .instr_rvalid_i     (instr_rvalid_i),
        .instr_rdata_i      (instr_rdata_i),
        .fetch_en_i         (fetch_en_i),
        .pc_start_address_i (pc_start_address_i),
        .branch_i           (branch_i),
        .branch_addr_i      (branch_addr_i),
        .ready_i            (ready_i),
        .valid_o            (valid_o),
        .instruction_o      (instruction_o),
        .program_count_o    (program_count_o),
        .empty_o            (empty_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample handshakes, advance to next negedge.
    task automatic cyc();
        if (mq_addr.size() != 0 && mq_due[0] <= cyc_n) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mq_addr[0] + 32'hA000;
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'h0;
        end
        #1;
        if (rst_n && valid_o && ready_i && !branch_i) begin
            check("pop_pc", program_count_o, exp_pc);
            check("pop_instr", instruction_o, exp_pc + 32'hA000);
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (rst_n && instr_gnt_i) begin
            mq_addr.push_back(instr_addr_o);
            mq_due.push_back(cyc_n + lat);
            last_gnt = instr_addr_o;
        end
        if (instr_rvalid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fetch_en_i = 1'b0;
        ready_i    = 1'b1;
        branch_i   = 1'b0;
        force_gnt  = 1'b0;
        gnt_stall  = 1'b0;
        cyc();
        cyc();
        mq_addr.delete();
        mq_due.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int found;
        int p0;
        n_checks = 0;
        n_pass   = 0;
        n_pops   = 0;
        cyc_n    = 0;
        lat      = 1;
        exp_pc   = 32'h0;
        last_gnt = 32'h0;
        rst_n    = 1'b0;
        instr_rvalid_i     = 1'b0;
        instr_rdata_i      = 32'h0;
        pc_start_address_i = 32'h100;
        branch_addr_i      = 32'h0;
        fetch_en_i = 1'b0;
        ready_i    = 1'b1;
        branch_i   = 1'b0;
        force_gnt  = 1'b0;
        gnt_stall  = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_req", 32'(instr_req_o), 32'd0);
        check("rst_addr", instr_addr_o, 32'h100);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instruction_o, 32'h0);
        check("rst_pc", program_count_o, 32'h0);
        check("rst_empty", 32'(empty_o), 32'd1);

        // Boot with zero-wait memory
        exp_pc     = 32'h100;
        n_pops     = 0;
        first      = -1;
        fetch_en_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) check("boot_req_idle", 32'(instr_req_o), 32'd0);
            if (i == 1) begin
                check("boot_req_rise", 32'(instr_req_o), 32'd1);
                check("boot_first_addr", instr_addr_o, 32'h100);
            end
            if (valid_o && first < 0) first = i;
            cyc();
        end
        check("boot_latency", 32'(first), 32'd3);
        check("boot_throughput", 32'(n_pops), 32'd13);

        // Backpressure fills the FIFO and stops requests
        ready_i = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("bp_req_low", 32'(instr_req_o), 32'd0);
        check("bp_valid", 32'(valid_o), 32'd1);
        check("bp_not_empty", 32'(empty_o), 32'd0);
        ready_i = 1'b1;
        p0 = n_pops;
        for (int i = 0; i < 4; i++) cyc();
        check("bp_release_pops", 32'(n_pops - p0), 32'd4);
        for (int i = 0; i < 6; i++) cyc();

        // Grant stall on 0x108
        do_reset();
        exp_pc     = 32'h100;
        fetch_en_i = 1'b1;
        found      = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_req_o && instr_addr_o == 32'h108) begin
                found = 1;
                break;
            end
            cyc();
        end
        check("stall_found", 32'(found), 32'd1);
        gnt_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(instr_req_o), 32'd1);
            check("stall_addr", instr_addr_o, 32'h108);
            cyc();
        end
        gnt_stall = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("stall_seq_end", exp_pc, last_gnt + 32'd4 - 32'(4 * (mq_addr.size())) -
              32'd4 * 32'(valid_o));

        // Branch with responses in flight and a grant in the branch cycle
        do_reset();
        lat        = 2;
        exp_pc     = 32'h100;
        fetch_en_i = 1'b1;
        found      = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_req_o && mq_addr.size() != 0) begin
                found = 1;
                break;
            end
            cyc();
        end
        check("br_setup", 32'(found), 32'd1);
        branch_i      = 1'b1;
        branch_addr_i = 32'h400;
        force_gnt     = 1'b1;
        cyc();
        branch_i  = 1'b0;
        force_gnt = 1'b0;
        exp_pc    = 32'h400;
        check("br_valid_low", 32'(valid_o), 32'd0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) begin
                found = 1;
                break;
            end
            cyc();
        end
        check("br_target_seen", 32'(found), 32'd1);
        check("br_target_pc", program_count_o, 32'h400);
        for (int i = 0; i < 10; i++) cyc();

        // Enable toggle with two requests outstanding
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (mq_addr.size() == 2) begin
                found = 1;
                break;
            end
            cyc();
        end
        check("en_setup", 32'(found), 32'd1);
        fetch_en_i = 1'b0;
        cyc();
        for (int i = 0; i < 8; i++) begin
            check("en_no_req", 32'(instr_req_o), 32'd0);
            cyc();
        end
        check("en_drained_empty", 32'(empty_o), 32'd1);
        check("en_all_delivered", exp_pc, last_gnt + 32'd4);
        fetch_en_i = 1'b1;
        cyc();
        check("en_resume_req", 32'(instr_req_o), 32'd1);
        check("en_resume_addr", instr_addr_o, exp_pc);
        for (int i = 0; i < 10; i++) cyc();

        // Address wrap at the top of the address space
        pc_start_address_i = 32'hFFFF_FFF8;
        do_reset();
        lat        = 1;
        exp_pc     = 32'hFFFF_FFF8;
        fetch_en_i = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check("wrap_pops", exp_pc, 32'h14);

        // Reset with the FIFO full
        pc_start_address_i = 32'h100;
        ready_i = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        check("mid_full_valid", 32'(valid_o), 32'd1);
        check("mid_full_req", 32'(instr_req_o), 32'd0);
        gnt_stall = 1'b1;
        rst_n     = 1'b0;
        cyc();
        mq_addr.delete();
        mq_due.delete();
        rst_n     = 1'b1;
        gnt_stall = 1'b0;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_empty", 32'(empty_o), 32'd1);
        check("mid_rst_addr", instr_addr_o, 32'h100);
        check("mid_rst_req", 32'(instr_req_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
